// File: rtl/byte_serial_logic_ctrl.sv
// byte_serial_logic_ctrl
// Computes a 32-bit AND/OR/XOR/NOR over four beats through one shared 8-bit
// logic slice, least-significant byte first. start/busy/done handshake.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; busy=0, done=0
// RUN    | one byte per edge, cnt selects the byte; busy=1
// DONE   | done=1 for one cycle; start here is accepted back-to-back
module byte_serial_logic_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        zero
);

   localparam int WIDTH = 32;
   localparam int SLICE = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [1:0]       r_cnt;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic             r_busy;
   logic             r_done;
   logic             r_zero;

   logic [SLICE-1:0] w_a_byte;
   logic [SLICE-1:0] w_b_byte;
   logic [SLICE-1:0] w_slice;
   logic [WIDTH-1:0] w_result_next;

   // Shared 8-bit slice: select the current byte of each latched operand,
   // apply the latched op, and merge it into the running result.
   always_comb begin
      w_a_byte      = r_a[{r_cnt, 3'b000} +: SLICE];
      w_b_byte      = r_b[{r_cnt, 3'b000} +: SLICE];
      w_slice       = '0;
      case (r_op)
         2'b00:   w_slice = w_a_byte & w_b_byte;
         2'b01:   w_slice = w_a_byte | w_b_byte;
         2'b10:   w_slice = w_a_byte ^ w_b_byte;
         2'b11:   w_slice = ~(w_a_byte | w_b_byte);
         default: w_slice = '0;
      endcase
      w_result_next = r_result;
      w_result_next[{r_cnt, 3'b000} +: SLICE] = w_slice;
   end

   // Sequencer with registered handshake outputs. Operands and op are only
   // sampled on the accepting edge, so X on op while idle never reaches state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 2'd0;
         r_op     <= 2'd0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_zero   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_op     <= op;
                  r_result <= '0;
                  r_cnt    <= 2'd0;
                  r_busy   <= 1'b1;
                  r_state  <= S_RUN;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_result <= w_result_next;
               r_cnt    <= r_cnt + 2'd1;
               // Leave on the last beat so cnt never wraps back into RUN.
               if (r_cnt == 2'd3) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_zero  <= (w_result_next == '0);
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign zero   = r_zero;

endmodule
